// File: rtl/count_pwm_if.sv
`default_nettype none
// ============================================================================
// count_pwm_if : Count/Enable inputs and PWM status outputs of count_pwm
// Rev 1.0
// ============================================================================
interface count_pwm_if;
    logic [3:0] Count;
    logic       Enable;
    logic       PwmOut;
    logic       PeriodDone;
    logic       Busy;
    logic [3:0] Duty;
    logic       Wrap;

    modport master (
        output Count,
        output Enable,
        input  PwmOut,
        input  PeriodDone,
        input  Busy,
        input  Duty,
        input  Wrap
    );

    modport slave (
        input  Count,
        input  Enable,
        output PwmOut,
        output PeriodDone,
        output Busy,
        output Duty,
        output Wrap
    );
endinterface
`default_nettype wire

// File: rtl/count_pwm.sv
`default_nettype none
// ============================================================================
// count_pwm : 16-step PWM driven by a 4-bit counter value, plus wrap detection
// Rev 1.0
// ============================================================================
module count_pwm #(
    parameter int PRESCALE = 1
) (
    input  wire logic   Clk,
    input  wire logic   reset,
    count_pwm_if.slave  bus
);

    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [3:0]      PH_LAST = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PS_W-1:0] prescaler;
    logic [PS_W-1:0] prescaler_next;
    logic [3:0]      phase;
    logic [3:0]      phase_next;
    logic [3:0]      duty;
    logic [3:0]      duty_next;

    logic            busy;
    logic            tick;
    logic            period_end;

    logic [3:0]      count_prev;
    logic            hist_valid;
    logic            wrap;

    assign busy       = (state != IDLE);
    assign tick       = busy && (prescaler == PS_LAST);
    assign period_end = tick && (phase == PH_LAST);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            phase     <= '0;
            duty      <= '0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            phase     <= phase_next;
            duty      <= duty_next;
        end
    end

    always_comb begin
        state_next     = state;
        prescaler_next = prescaler;
        phase_next     = phase;
        duty_next      = duty;

        case (state)
            IDLE: begin
                if (bus.Enable) begin
                    state_next     = RUN;
                    duty_next      = bus.Count;
                    phase_next     = '0;
                    prescaler_next = '0;
                end
            end

            RUN: begin
                prescaler_next = tick ? '0 : prescaler + PS_W'(1);
                if (tick) begin
                    phase_next = phase + 4'd1;
                end
                if (period_end) begin
                    duty_next = bus.Count;
                end
                if (!bus.Enable) begin
                    state_next = DRAIN;
                end
            end

            DRAIN: begin
                // Same timing as RUN, but the duty is frozen for the final period.
                prescaler_next = tick ? '0 : prescaler + PS_W'(1);
                if (tick) begin
                    phase_next = phase + 4'd1;
                end
                if (bus.Enable) begin
                    state_next = RUN;
                end else if (period_end) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next     = IDLE;
                prescaler_next = '0;
                phase_next     = '0;
            end
        endcase
    end

    // Wrap history runs regardless of the PWM state machine.
    always_ff @(posedge Clk) begin
        count_prev <= bus.Count;
        if (reset) begin
            hist_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            hist_valid <= 1'b1;
            wrap       <= hist_valid &&
                          (((count_prev == 4'd15) && (bus.Count == 4'd0)) ||
                           ((count_prev == 4'd0)  && (bus.Count == 4'd15)));
        end
    end

    assign bus.PwmOut     = busy && (phase < duty);
    assign bus.PeriodDone = period_end;
    assign bus.Busy       = busy;
    assign bus.Duty       = duty;
    assign bus.Wrap       = wrap;

endmodule
`default_nettype wire

// File: tb/tb_count_pwm.sv
`default_nettype none
// ============================================================================
// tb_count_pwm : directed bench for count_pwm at PRESCALE=1 and PRESCALE=4
// Rev 1.0
// ============================================================================
module tb_count_pwm;

    logic Clk;
    logic reset;
    int   vectors;
    int   miscompares;

    count_pwm_if if1 ();
    count_pwm_if if4 ();

    count_pwm #(.PRESCALE(1)) dut1 (.Clk(Clk), .reset(reset), .bus(if1));
    count_pwm #(.PRESCALE(4)) dut4 (.Clk(Clk), .reset(reset), .bus(if4));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held with Enable high: nothing may start.
        reset      = 1'b1;
        if1.Enable = 1'b1;
        if1.Count  = 4'd9;
        if4.Enable = 1'b1;
        if4.Count  = 4'd9;
        cyc();
        cyc();
        chk("rst_busy",  8'(if1.Busy), 8'd0);
        chk("rst_pwm",   8'(if1.PwmOut), 8'd0);
        chk("rst_duty",  8'(if1.Duty), 8'd0);
        chk("rst_pd",    8'(if1.PeriodDone), 8'd0);
        chk("rst_wrap",  8'(if1.Wrap), 8'd0);
        chk("rst_busy4", 8'(if4.Busy), 8'd0);

        // Release reset with Enable low, then start at duty 5.
        if1.Enable = 1'b0;
        if4.Enable = 1'b0;
        if1.Count  = 4'd5;
        reset      = 1'b0;
        cyc();
        chk("idle_busy", 8'(if1.Busy), 8'd0);
        if1.Enable = 1'b1;
        cyc();
        chk("start_busy", 8'(if1.Busy), 8'd1);
        chk("start_duty", 8'(if1.Duty), 8'd5);
        for (int k = 0; k < 32; k++) begin
            chk("d5_pwm", 8'(if1.PwmOut), 8'((k % 16) < 5));
            chk("d5_pd",  8'(if1.PeriodDone), 8'((k % 16) == 15));
            cyc();
        end

        // Count moves mid-period; current period keeps duty 5.
        for (int k = 0; k < 16; k++) begin
            if (k == 3) if1.Count = 4'd12;
            chk("mid_pwm",  8'(if1.PwmOut), 8'(k < 5));
            chk("mid_duty", 8'(if1.Duty), 8'd5);
            cyc();
        end
        chk("d12_duty", 8'(if1.Duty), 8'd12);
        for (int k = 0; k < 16; k++) begin
            if (k == 0) if1.Count = 4'd0;
            chk("d12_pwm", 8'(if1.PwmOut), 8'(k < 12));
            chk("d12_pd",  8'(if1.PeriodDone), 8'(k == 15));
            cyc();
        end

        // Duty 0 for three periods, then duty 15.
        for (int k = 0; k < 48; k++) begin
            if (k == 32) if1.Count = 4'd15;
            chk("d0_pwm",  8'(if1.PwmOut), 8'd0);
            chk("d0_duty", 8'(if1.Duty), 8'd0);
            cyc();
        end
        chk("d15_duty", 8'(if1.Duty), 8'd15);
        for (int k = 0; k < 16; k++) begin
            if (k == 0) if1.Count = 4'd6;
            chk("d15_pwm", 8'(if1.PwmOut), 8'(k < 15));
            chk("d15_pd",  8'(if1.PeriodDone), 8'(k == 15));
            cyc();
        end

        // Graceful stop: Enable drops at phase 7; duty frozen through the drain.
        chk("d6_duty", 8'(if1.Duty), 8'd6);
        for (int k = 0; k < 16; k++) begin
            if (k == 7) if1.Enable = 1'b0;
            if (k == 8) if1.Count  = 4'd9;
            chk("drain_pwm",  8'(if1.PwmOut), 8'(k < 6));
            chk("drain_busy", 8'(if1.Busy), 8'd1);
            chk("drain_pd",   8'(if1.PeriodDone), 8'(k == 15));
            cyc();
        end
        chk("stop_busy", 8'(if1.Busy), 8'd0);
        chk("stop_pwm",  8'(if1.PwmOut), 8'd0);
        chk("stop_pd",   8'(if1.PeriodDone), 8'd0);
        chk("stop_duty", 8'(if1.Duty), 8'd6);

        // Restart; Enable dips at phase 7 and returns at phase 10.
        if1.Enable = 1'b1;
        cyc();
        chk("re_duty", 8'(if1.Duty), 8'd9);
        for (int k = 0; k < 16; k++) begin
            if (k == 0)  if1.Count  = 4'd3;
            if (k == 7)  if1.Enable = 1'b0;
            if (k == 10) if1.Enable = 1'b1;
            chk("re_pwm",  8'(if1.PwmOut), 8'(k < 9));
            chk("re_busy", 8'(if1.Busy), 8'd1);
            chk("re_pd",   8'(if1.PeriodDone), 8'(k == 15));
            cyc();
        end
        chk("re_busy_after", 8'(if1.Busy), 8'd1);
        chk("re_resample",   8'(if1.Duty), 8'd3);

        // Enable falls on the period-end cycle: resample, then one full drain period.
        for (int k = 0; k < 16; k++) begin
            if (k == 0)  if1.Count  = 4'd2;
            if (k == 15) if1.Enable = 1'b0;
            chk("d3_pwm", 8'(if1.PwmOut), 8'(k < 3));
            cyc();
        end
        chk("edge_duty", 8'(if1.Duty), 8'd2);
        for (int k = 0; k < 16; k++) begin
            chk("edge_pwm",  8'(if1.PwmOut), 8'(k < 2));
            chk("edge_busy", 8'(if1.Busy), 8'd1);
            chk("edge_pd",   8'(if1.PeriodDone), 8'(k == 15));
            cyc();
        end
        chk("edge_idle", 8'(if1.Busy), 8'd0);

        // PRESCALE=4, duty 8: 32 high, 32 low, PeriodDone every 64 cycles.
        if4.Count  = 4'd8;
        if4.Enable = 1'b1;
        cyc();
        chk("p4_duty", 8'(if4.Duty), 8'd8);
        for (int k = 0; k < 128; k++) begin
            chk("p4_pwm", 8'(if4.PwmOut), 8'((k % 64) < 32));
            chk("p4_pd",  8'(if4.PeriodDone), 8'((k % 64) == 63));
            cyc();
        end
        if4.Enable = 1'b0;

        // Reset at phase 3 aborts immediately.
        if1.Count  = 4'd5;
        if1.Enable = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("pre_rst_pwm", 8'(if1.PwmOut), 8'd1);
            cyc();
        end
        reset      = 1'b1;
        if1.Enable = 1'b0;
        if1.Count  = 4'd15;
        cyc();
        chk("abort_busy", 8'(if1.Busy), 8'd0);
        chk("abort_pwm",  8'(if1.PwmOut), 8'd0);
        chk("abort_pd",   8'(if1.PeriodDone), 8'd0);
        chk("abort_duty", 8'(if1.Duty), 8'd0);
        chk("abort_wrap", 8'(if1.Wrap), 8'd0);

        // 15 during reset, 0 right after: history not yet valid.
        reset     = 1'b0;
        if1.Count = 4'd0;
        cyc();
        chk("nowrap_a", 8'(if1.Wrap), 8'd0);
        cyc();
        chk("nowrap_b", 8'(if1.Wrap), 8'd0);

        // 14,15,0,1 then 0,15.
        if1.Count = 4'd14; cyc(); chk("w14", 8'(if1.Wrap), 8'd0);
        if1.Count = 4'd15; cyc(); chk("w15", 8'(if1.Wrap), 8'd0);
        if1.Count = 4'd0;  cyc(); chk("w0",  8'(if1.Wrap), 8'd1);
        if1.Count = 4'd1;  cyc(); chk("w1",  8'(if1.Wrap), 8'd0);
        if1.Count = 4'd0;  cyc(); chk("w1_0", 8'(if1.Wrap), 8'd0);
        if1.Count = 4'd15; cyc(); chk("w0_15", 8'(if1.Wrap), 8'd1);
        cyc();             chk("w15_hold", 8'(if1.Wrap), 8'd0);
        chk("w_idle", 8'(if1.Busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_pwm.md
Name: count_pwm

Overview:
Downstream consumer of the 4-bit up/down counter's Count bus, in the same clock domain. Converts the Count value into a 16-step PWM waveform and flags counter wrap-around (15->0 or 0->15). Duty is sampled into a shadow register only at period boundaries, so the waveform is glitch-free. An Enable-driven FSM provides a graceful stop: the current period always completes.

Parameters:
PRESCALE, 1, number of Clk cycles per PWM step; legal range 1..256.

Ports:
Clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset; sampled on the rising edge of Clk.
Count  input  4  counter value, same clock domain; used as duty (0..15).
Enable  input  1  level; 1 = run PWM, 0 = stop at the end of the current period.
PwmOut  output  1  PWM waveform.
PeriodDone  output  1  one-cycle pulse on the final tick of each period.
Busy  output  1  1 in RUN or DRAIN.
Duty  output  4  current shadow duty value.
Wrap  output  1  one-cycle pulse when Count wraps (15->0 or 0->15).

Behaviour:
- Reset (synchronous, priority over everything):
  - Next edge: state=IDLE, phase=0, prescaler=0, Duty=0, PwmOut=0, PeriodDone=0, Busy=0, Wrap=0.
  - Count-previous history is marked invalid.
  - Reset in RUN or DRAIN aborts immediately; no PeriodDone pulse.
- Tick generation:
  - Prescaler counts 0..PRESCALE-1 while state is RUN or DRAIN.
  - tick=1 in the cycle where prescaler==PRESCALE-1.
  - PRESCALE=1 gives tick every cycle.
  - Prescaler is held at 0 in IDLE and cleared on entering RUN.
- Phase counter:
  - 4-bit; increments on tick.
  - Wraps 15->0 on tick when phase==15; this is the period end.
- FSM:
  - IDLE: Enable=1 -> RUN next cycle, with Duty<=Count sampled at that edge, phase<=0, prescaler<=0. Otherwise stay.
  - RUN: at period end, Duty<=Count and PeriodDone=1 for one cycle. Enable=0 (checked every cycle) -> DRAIN; phase, Duty and prescaler continue undisturbed.
  - DRAIN: behaves as RUN. Enable=1 -> RUN with no restart. At period end: PeriodDone=1, Duty held (not resampled), ->IDLE, phase=0.
- Duty changes only at the IDLE->RUN edge and at period ends in RUN. Count changes mid-period are ignored until the next boundary.
- PwmOut:
  - PwmOut = Busy AND (phase < Duty), decoded from registered state.
  - High for Duty steps, low for 16-Duty steps, within each 16*PRESCALE-cycle period.
  - Duty=0: constantly low. Duty=15: high 15 of 16 steps; no 100% mode.
- Busy = (state != IDLE).
- Wrap detection, independent of FSM and Enable:
  - Register CountPrev every cycle.
  - Wrap=1 for one cycle when history is valid and (CountPrev==15 and Count==0) or (CountPrev==0 and Count==15).
  - History becomes valid one cycle after reset deasserts.
  - Wrap is registered: the pulse appears the cycle after the wrap is seen on Count.
- Simultaneous events:
  - Enable falling on the period-end cycle in RUN: resample Duty and go to DRAIN; a full further period runs.
  - Enable asserted and reset on the same edge: reset wins.
- Arithmetic is unsigned 4-bit; phase wrap is modulo 16. PRESCALE counter width is clog2(PRESCALE) bits (minimum 1).

Test Plan:
1. Reset: hold reset 2 cycles with Enable=1, Count=9 -> PwmOut=0, Busy=0, Duty=0, PeriodDone=0, Wrap=0; IDLE persists while reset is high.
2. PRESCALE=1, Count=5, raise Enable -> Busy=1 next cycle, Duty=5. PwmOut high 5 cycles, low 11. PeriodDone pulses on the 16th cycle. Pattern repeats.
3. Mid-period update: Duty=5 running, Count 5->12 at phase 3 -> current period keeps 5 high; next period Duty=12, 12 high, 4 low.
4. Extremes: Count=0 -> PwmOut never high over 3 periods. Count=15 -> high 15, low 1, per period. PRESCALE=4, Count=8 -> 32 cycles high, 32 low, PeriodDone every 64 cycles.
5. Graceful stop: drop Enable at phase 7 -> output continues through phase 15, PeriodDone pulses, then Busy=0 and PwmOut=0. Re-raise Enable at phase 10 instead -> no interruption, Busy stays 1.
6. Reset mid-run at phase 3 -> next cycle IDLE, all outputs 0, no PeriodDone. Drive Count 14,15,0,1 -> one Wrap pulse, the cycle after Count=0. Drive Count 1,0,15 -> one Wrap pulse. Count=15 then 0 on the first cycle after reset -> no Wrap.
